// File: rtl/input_bin_credit_sched.sv
// Credit scheduler for the per-unit input bins: reserves worst-case space per block,
// reconciles with the real track counts PIPE_LAT cycles later and tracks unit pops.

module input_bin_credit_unit #(
    parameter int STREAM_WIDTH        = 8,
    parameter int LOG_STREAM_WIDTH    = 3,
    parameter int BITS_INPUT_BIN_ADDR = 5
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         i_accept,
    input  logic                         i_arrive,
    input  logic [BITS_INPUT_BIN_ADDR:0] i_cnt,
    input  logic                         i_pop_req,
    output logic                         o_pop_ack,
    output logic                         o_space_ok,
    output logic                         o_idle,
    output logic                         o_ovf,
    output logic [BITS_INPUT_BIN_ADDR:0] o_occ,
    output logic                         o_empty
);
    localparam int CW    = BITS_INPUT_BIN_ADDR + 1;
    localparam int CWP   = CW + 1;
    localparam int DEPTH = 1 << BITS_INPUT_BIN_ADDR;
    localparam logic [CW-1:0] SW_C    = CW'(STREAM_WIDTH);
    localparam logic [CW:0]   DEPTH_C = CWP'(DEPTH);

    logic [CW-1:0] r_occ;
    logic [CW-1:0] r_rsv;
    logic          r_empty;
    logic          w_ovf;
    logic [CW-1:0] w_add;
    logic [CW-1:0] w_occ_nxt;
    logic [CW-1:0] w_rsv_nxt;
    logic [CW:0]   w_used;
    logic [CW:0]   w_free;

    assign w_ovf  = (i_cnt > SW_C);
    assign w_add  = w_ovf ? SW_C : i_cnt;
    assign o_ovf  = i_arrive & w_ovf;

    // Registered occupancy gates the pop, so a same-cycle arrival cannot fund it.
    assign o_pop_ack = i_pop_req & (r_occ != '0);

    assign w_occ_nxt = r_occ + (i_arrive ? w_add : '0) - {{(CW-1){1'b0}}, o_pop_ack};
    assign w_rsv_nxt = r_rsv + (i_accept ? SW_C : '0) - (i_arrive ? SW_C : '0);

    // occ + rsv never exceeds DEPTH, so the free count cannot wrap.
    assign w_used     = {1'b0, r_occ} + {1'b0, r_rsv};
    assign w_free     = DEPTH_C - w_used;
    assign o_space_ok = |(w_free >> LOG_STREAM_WIDTH);
    assign o_idle     = (r_occ == '0) && (r_rsv == '0);
    assign o_occ      = r_occ;
    assign o_empty    = r_empty;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_occ   <= '0;
            r_rsv   <= '0;
            r_empty <= 1'b1;
        end else begin
            r_occ   <= w_occ_nxt;
            r_rsv   <= w_rsv_nxt;
            r_empty <= (w_occ_nxt == '0);
        end
    end
endmodule

module input_bin_credit_sched #(
    parameter int NUM_UNITs           = 8,
    parameter int STREAM_WIDTH        = 8,
    parameter int LOG_STREAM_WIDTH    = 3,
    parameter int BITS_INPUT_BIN_ADDR = 5,
    parameter int PIPE_LAT            = 6
) (
    input  logic                                         clk,
    input  logic                                         rst_b,
    input  logic                                         start,
    input  logic                                         blk_valid,
    input  logic                                         blk_last,
    output logic                                         blk_ready,
    output logic                                         blk_accept,
    input  logic [NUM_UNITs-1:0][BITS_INPUT_BIN_ADDR:0]  set_track_ctr_pb,
    input  logic [NUM_UNITs-1:0]                         pop_req,
    output logic [NUM_UNITs-1:0]                         pop_ack,
    output logic [NUM_UNITs-1:0][BITS_INPUT_BIN_ADDR:0]  occupancy,
    output logic [NUM_UNITs-1:0]                         bin_empty,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         err
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  r_state;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic [PIPE_LAT:1]       r_vld_pipe;
    logic                    w_arrive;
    logic [NUM_UNITs-1:0]    w_space_ok;
    logic [NUM_UNITs-1:0]    w_idle;
    logic [NUM_UNITs-1:0]    w_ovf;

    // Bit k of the pipe marks a block accepted k cycles ago; the tail is the count arrival.
    assign w_arrive   = r_vld_pipe[PIPE_LAT];
    assign blk_ready  = (r_state == S_RUN) & (&w_space_ok);
    assign blk_accept = blk_valid & blk_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

    for (genvar g = 0; g < NUM_UNITs; g++) begin : g_unit
        input_bin_credit_unit #(
            .STREAM_WIDTH        (STREAM_WIDTH),
            .LOG_STREAM_WIDTH    (LOG_STREAM_WIDTH),
            .BITS_INPUT_BIN_ADDR (BITS_INPUT_BIN_ADDR)
        ) u_unit (
            .clk        (clk),
            .rst_b      (rst_b),
            .i_accept   (blk_accept),
            .i_arrive   (w_arrive),
            .i_cnt      (set_track_ctr_pb[g]),
            .i_pop_req  (pop_req[g]),
            .o_pop_ack  (pop_ack[g]),
            .o_space_ok (w_space_ok[g]),
            .o_idle     (w_idle[g]),
            .o_ovf      (w_ovf[g]),
            .o_occ      (occupancy[g]),
            .o_empty    (bin_empty[g])
        );
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_vld_pipe <= '0;
            r_err      <= 1'b0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[PIPE_LAT-1:1], blk_accept};
            r_err      <= r_err | (|w_ovf);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (blk_accept && blk_last) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if ((r_vld_pipe == '0) && (&w_idle)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_input_bin_credit_sched.sv
// Directed bench for input_bin_credit_sched: a queue-based bin/credit model checked
// every cycle, plus literal expectations at the key points of each scenario.

module tb_input_bin_credit_sched;
    localparam int N     = 8;
    localparam int SW    = 8;
    localparam int DEPTH = 32;
    localparam int PL    = 6;
    localparam int CW    = 6;

    typedef logic [N-1:0][CW-1:0] cnt_t;
    typedef struct { int due; cnt_t cnt; } fl_t;
    typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mst_t;

    localparam cnt_t JUNK = {N{6'd9}};

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic         start = 1'b0;
    logic         blk_valid = 1'b0;
    logic         blk_last = 1'b0;
    logic         blk_ready, blk_accept, busy, done, err;
    cnt_t         set_track_ctr_pb = JUNK;
    cnt_t         occupancy;
    logic [N-1:0] pop_req = '0;
    logic [N-1:0] pop_ack, bin_empty;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   m_occ[N];
    int   m_rsv[N];
    bit   m_err;
    mst_t m_state = M_IDLE;
    fl_t  inflight[$];
    cnt_t pend_q[$];

    input_bin_credit_sched dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .start            (start),
        .blk_valid        (blk_valid),
        .blk_last         (blk_last),
        .blk_ready        (blk_ready),
        .blk_accept       (blk_accept),
        .set_track_ctr_pb (set_track_ctr_pb),
        .pop_req          (pop_req),
        .pop_ack          (pop_ack),
        .occupancy        (occupancy),
        .bin_empty        (bin_empty),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic cnt_t all_v(input int v);
        cnt_t c;
        for (int u = 0; u < N; u++) c[u] = CW'(v);
        return c;
    endfunction

    function automatic cnt_t one_hot(input int u0, input int v);
        cnt_t c = '0;
        c[u0] = CW'(v);
        return c;
    endfunction

    // Upstream counter pipeline: real counts only on the due cycle, junk otherwise.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (inflight.size() > 0 && inflight[0].due == cyc) set_track_ctr_pb = inflight[0].cnt;
        else set_track_ctr_pb = JUNK;
    end

    // Model: compare current outputs, then advance to the state after the coming edge.
    always @(negedge clk) begin
        bit           rdy;
        bit           acc;
        bit           drained;
        logic [N-1:0] ep;
        logic [N-1:0] eemp;
        cnt_t         eocc;
        fl_t          f;
        int           c;
        if (!rst_b) begin
            for (int u = 0; u < N; u++) begin
                m_occ[u] = 0;
                m_rsv[u] = 0;
            end
            m_err   = 0;
            m_state = M_IDLE;
            inflight.delete();
            pend_q.delete();
        end
        rdy = (m_state == M_RUN);
        for (int u = 0; u < N; u++) begin
            if (m_occ[u] + m_rsv[u] > DEPTH - SW) rdy = 0;
            ep[u]   = pop_req[u] && (m_occ[u] != 0);
            eocc[u] = CW'(m_occ[u]);
            eemp[u] = (m_occ[u] == 0);
        end
        acc = blk_valid && rdy;
        chk("blk_ready", blk_ready, rdy);
        chk("blk_accept", blk_accept, acc);
        chk("pop_ack", pop_ack, ep);
        chk("occupancy", occupancy, eocc);
        chk("bin_empty", bin_empty, eemp);
        chk("busy", busy, m_state != M_IDLE);
        chk("done", done, m_state == M_DONE);
        chk("err", err, m_err);
        if (rst_b) begin
            drained = (inflight.size() == 0);
            for (int u = 0; u < N; u++)
                if (m_occ[u] != 0 || m_rsv[u] != 0) drained = 0;
            if (inflight.size() > 0 && inflight[0].due == cyc) begin
                for (int u = 0; u < N; u++) begin
                    c = int'(inflight[0].cnt[u]);
                    if (c > SW) begin
                        m_err = 1;
                        c = SW;
                    end
                    m_occ[u] += c;
                    m_rsv[u] -= SW;
                end
                void'(inflight.pop_front());
            end
            for (int u = 0; u < N; u++) if (ep[u]) m_occ[u] -= 1;
            if (acc) begin
                n_acc++;
                for (int u = 0; u < N; u++) m_rsv[u] += SW;
                f.due = cyc + PL;
                if (pend_q.size() > 0) f.cnt = pend_q.pop_front();
                else f.cnt = '0;
                inflight.push_back(f);
            end
            case (m_state)
                M_IDLE:  if (start) m_state = M_RUN;
                M_RUN:   if (acc && blk_last) m_state = M_DRAIN;
                M_DRAIN: if (drained) m_state = M_DONE;
                default: m_state = M_IDLE;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_stream();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_block(input bit last, input cnt_t cv);
        int n0 = n_acc;
        bit got = 0;
        pend_q.push_back(cv);
        blk_valid = 1'b1;
        blk_last  = last;
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            if (n_acc != n0) got = 1;
        end
        blk_valid = 1'b0;
        blk_last  = 1'b0;
        chk("accept_wait", got, 1);
    endtask

    task automatic finish_stream();
        bit seen = 0;
        pop_req = '1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("done_pulse_seen", seen, 1);
        tick();
        pop_req = '0;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        @(negedge clk);
        chk("rst_ready", blk_ready, 0);
        chk("rst_empty", bin_empty, 8'hFF);
        chk("rst_busy", busy, 0);
        tick();
        rst_b = 1'b1;
        tick();

        // Single block, all elements to unit 0.
        begin_stream();
        send_block(1, one_hot(0, 8));
        repeat (PL) tick();
        @(negedge clk);
        chk("t1_occ0", occupancy[0], 8);
        chk("t1_empty0", bin_empty[0], 0);
        chk("t1_busy", busy, 1);
        tick();
        finish_stream();

        // Back-to-back blocks until reservations fill the bins.
        begin_stream();
        repeat (4) send_block(0, all_v(1));
        @(negedge clk);
        chk("t2_full_ready", blk_ready, 0);
        tick();
        send_block(1, all_v(0));
        repeat (PL + 2) tick();
        @(negedge clk);
        chk("t2_occ_all4", occupancy, all_v(4));
        tick();
        finish_stream();

        // Unit 3 alone fills to 25; one pop reopens.
        begin_stream();
        repeat (3) send_block(0, one_hot(3, 8));
        send_block(0, one_hot(3, 1));
        repeat (PL + 2) tick();
        @(negedge clk);
        chk("t3_occ3", occupancy[3], 25);
        chk("t3_blocked", blk_ready, 0);
        tick();
        pop_req[3] = 1'b1;
        tick();
        pop_req = '0;
        @(negedge clk);
        chk("t3_reopen", blk_ready, 1);
        chk("t3_occ3_pop", occupancy[3], 24);
        tick();
        send_block(1, all_v(0));
        finish_stream();

        // Pop on an empty bin in the same cycle its count arrives.
        begin_stream();
        send_block(1, one_hot(2, 2));
        repeat (PL - 1) tick();
        pop_req[2] = 1'b1;
        @(negedge clk);
        chk("t4_ack_denied", pop_ack[2], 0);
        tick();
        @(negedge clk);
        chk("t4_occ2", occupancy[2], 2);
        chk("t4_ack_granted", pop_ack[2], 1);
        tick();
        pop_req = '0;
        @(negedge clk);
        chk("t4_occ2_after", occupancy[2], 1);
        tick();
        finish_stream();

        // Oversized count is flagged and clamped.
        begin_stream();
        send_block(1, one_hot(5, 9));
        repeat (PL) tick();
        @(negedge clk);
        chk("t5_err", err, 1);
        chk("t5_occ5_clamped", occupancy[5], 8);
        tick();
        finish_stream();
        chk("t5_err_sticky", err, 1);

        // Reset while draining with four blocks in flight.
        begin_stream();
        repeat (3) send_block(0, all_v(2));
        send_block(1, all_v(3));
        tick();
        rst_b = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_ready", blk_ready, 0);
        chk("t6_err", err, 0);
        chk("t6_done", done, 0);
        chk("t6_empty", bin_empty, 8'hFF);
        chk("t6_occ", occupancy, 0);
        tick();
        tick();
        rst_b = 1'b1;
        repeat (12) tick();
        @(negedge clk);
        chk("t6_occ_late", occupancy, 0);
        chk("t6_err_late", err, 0);
        chk("t6_idle_late", busy, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
